// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants and helpers for the instruction fetch block.
//               INSTR_W      - instruction word width
//               NOP_INSTR    - value returned by never-written memory
//               LANE_OFFSET  - byte distance between adjacent fetch lanes
//               bundle_stride() - fetch PC advance per issued bundle
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int          INSTR_W     = 32;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam int          LANE_OFFSET = 4;

    typedef logic [INSTR_W-1:0] instr_t;

    // Byte distance the fetch PC moves for one bundle of issue_w lanes.
    function automatic int bundle_stride(input int issue_w);
        return LANE_OFFSET * issue_w;
    endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/instr_fetch_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_buffer_if
// Description : Valid/ready bundle channel from fetch to decode.
//               out_valid - head bundle valid        (fetch -> decode)
//               out_ready - decode accepts head      (decode -> fetch)
//               out_pc    - PC of lane 0             (fetch -> decode)
//               out_instr - ISSUE_W packed lanes     (fetch -> decode)
//               master modport: fetch side, slave modport: decode side.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_buffer_if #(
    parameter int ISSUE_W = 2,
    parameter int PC_W    = 64
) ();

    logic                  out_valid;
    logic                  out_ready;
    logic [PC_W-1:0]       out_pc;
    logic [ISSUE_W*32-1:0] out_instr;

    modport master (
        output out_valid,
        output out_pc,
        output out_instr,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_pc,
        input  out_instr,
        output out_ready
    );

endinterface : instr_fetch_buffer_if
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Synchronous FIFO of fetch bundles with flush.
//               clk, rst_n    - clock, synchronous active-low reset
//               flush_i       - drop all entries (wins over push/pop)
//               push_i        - write push_data_i at tail
//               push_data_i   - bundle to enqueue
//               pop_i         - remove head (ignored when empty)
//               head_data_o   - current head bundle
//               count_o       - number of entries held (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       flush_i,
    input  wire logic                       push_i,
    input  wire logic [WIDTH-1:0]           push_data_i,
    input  wire logic                       pop_i,
    output logic      [WIDTH-1:0]           head_data_o,
    output logic      [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] entries_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             pop_ok;

    assign pop_ok = pop_i && (count_q != '0);

    // DEPTH is a power of two, so pointers wrap by natural overflow. When
    // full, push and pop hit the same slot: the head is read before the edge
    // and overwritten at it, which is exactly the desired behaviour.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                entries_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q            <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_ok);
        end
    end

    assign head_data_o = entries_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule : fetch_queue
`default_nettype wire

// File: rtl/instr_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_buffer
// Description : ISSUE_W-wide instruction fetch with synchronous-read memory,
//               runtime program load, branch redirect/flush and a bundle
//               queue toward decode.
//               clk, rst_n      - clock, synchronous active-low reset
//               load_en/addr/data - write one 32-bit word (addr[1:0] ignored)
//               redirect_en/pc  - flush and refetch from redirect_pc
//               misalign_fault  - sticky, set by redirect to unaligned PC
//               out_bus         - valid/ready bundle channel (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int ISSUE_W = 2,
    parameter int ADDR_W  = 16,
    parameter int PC_W    = 64,
    parameter int QDEPTH  = 4
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               load_en,
    input  wire logic [ADDR_W-1:0]  load_addr,
    input  wire logic [31:0]        load_data,
    input  wire logic               redirect_en,
    input  wire logic [PC_W-1:0]    redirect_pc,
    output logic                    misalign_fault,
    instr_fetch_buffer_if.master    out_bus
);

    localparam int WORD_AW   = ADDR_W - 2;
    localparam int MEM_WORDS = 1 << WORD_AW;
    localparam int CNT_W     = $clog2(QDEPTH) + 1;
    localparam logic [PC_W-1:0] FPC_STEP = PC_W'(bundle_stride(ISSUE_W));

    typedef struct packed {
        logic [PC_W-1:0]                 pc;
        logic [ISSUE_W-1:0][INSTR_W-1:0] instr;
    } bundle_t;

    localparam int BUNDLE_W = $bits(bundle_t);

    // ------------------------------------------------------------------
    // Instruction memory. Words are stored XOR-ed with NOP_INSTR so that
    // the all-zero power-up contents read back as NOP without needing an
    // initialisation pass; reset intentionally leaves the array untouched.
    // Fetch PCs are always word aligned (an unaligned redirect halts fetch),
    // so per-lane byte wrap equals word-index wrap.
    // ------------------------------------------------------------------
    instr_t mem_q [MEM_WORDS];

    logic [WORD_AW-1:0]              lane_idx [ISSUE_W];
    logic [PC_W-1:0]                 fpc_q;
    logic                            fault_q;
    logic                            inflight_q;
    logic [PC_W-1:0]                 rd_pc_q;
    logic [ISSUE_W-1:0][INSTR_W-1:0] rd_instr_q;

    logic [CNT_W-1:0]                q_count;
    logic [CNT_W:0]                  credit_used;
    logic                            issue;
    logic                            push;
    logic                            pop;
    logic                            out_valid_w;
    bundle_t                         push_bundle;
    bundle_t                         head_bundle;
    logic [BUNDLE_W-1:0]             head_raw;
    logic                            unused_load_lsb;

    assign unused_load_lsb = ^load_addr[1:0];

    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_q[load_addr[ADDR_W-1:2]] <= load_data ^ NOP_INSTR;
        end
    end

    for (genvar i = 0; i < ISSUE_W; i++) begin : g_lane
        assign lane_idx[i] = fpc_q[ADDR_W-1:2] + WORD_AW'(i);
    end

    // ------------------------------------------------------------------
    // Issue control. Credits count queued bundles plus the one read in
    // flight, so a bundle always has a slot when it lands one cycle later.
    // ------------------------------------------------------------------
    assign credit_used = (CNT_W+1)'(q_count) + (CNT_W+1)'(inflight_q);
    assign issue = rst_n && !redirect_en && !load_en && !fault_q &&
                   (credit_used < (CNT_W+1)'(QDEPTH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fpc_q      <= '0;
            fault_q    <= 1'b0;
            inflight_q <= 1'b0;
        end else if (redirect_en) begin
            fpc_q      <= redirect_pc;
            fault_q    <= |redirect_pc[1:0];
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                fpc_q <= fpc_q + FPC_STEP;
            end
        end
    end

    // Read data register; only meaningful while inflight_q is set.
    always_ff @(posedge clk) begin
        if (issue) begin
            rd_pc_q <= fpc_q;
            for (int i = 0; i < ISSUE_W; i++) begin
                rd_instr_q[i] <= mem_q[lane_idx[i]] ^ NOP_INSTR;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bundle queue. A redirect flushes it and suppresses both the landing
    // read and any pop offered in the same cycle.
    // ------------------------------------------------------------------
    assign push_bundle = '{pc: rd_pc_q, instr: rd_instr_q};
    assign push        = inflight_q && !redirect_en;
    assign out_valid_w = (q_count != '0);
    assign pop         = out_valid_w && out_bus.out_ready && !redirect_en;

    fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (BUNDLE_W)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect_en),
        .push_i      (push),
        .push_data_i (push_bundle),
        .pop_i       (pop),
        .head_data_o (head_raw),
        .count_o     (q_count)
    );

    assign head_bundle       = bundle_t'(head_raw);
    assign out_bus.out_valid = out_valid_w;
    assign out_bus.out_pc    = head_bundle.pc;
    assign out_bus.out_instr = head_bundle.instr;
    assign misalign_fault    = fault_q;

endmodule : instr_fetch_buffer
`default_nettype wire

// File: tb/tb_instr_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_buffer
// Description : Directed self-checking bench for instr_fetch_buffer
//               (ISSUE_W=2, ADDR_W=16, PC_W=64, QDEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_buffer;

    localparam int ISSUE_W = 2;
    localparam int ADDR_W  = 16;
    localparam int PC_W    = 64;
    localparam int QDEPTH  = 4;
    localparam logic [63:0] NOP2 = 64'h00000013_00000013;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;
    logic              redirect_en;
    logic [PC_W-1:0]   redirect_pc;
    logic              misalign_fault;

    int checks   = 0;
    int failures = 0;

    instr_fetch_buffer_if #(.ISSUE_W(ISSUE_W), .PC_W(PC_W)) bus ();

    instr_fetch_buffer #(
        .ISSUE_W (ISSUE_W),
        .ADDR_W  (ADDR_W),
        .PC_W    (PC_W),
        .QDEPTH  (QDEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_en        (load_en),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .misalign_fault (misalign_fault),
        .out_bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic redirect(input logic [PC_W-1:0] pc);
        redirect_en = 1'b1;
        redirect_pc = pc;
        tick();
        redirect_en = 1'b0;
    endtask

    task automatic expect_bundle(input string tag, input logic [63:0] pc, input logic [63:0] ins);
        check({tag, "_valid"}, 128'(bus.out_valid), 128'(1'b1));
        check({tag, "_pc"},    128'(bus.out_pc),    128'(pc));
        check({tag, "_instr"}, 128'(bus.out_instr), 128'(ins));
    endtask

    initial begin
        rst_n         = 1'b0;
        load_en       = 1'b0;
        load_addr     = '0;
        load_data     = '0;
        redirect_en   = 1'b0;
        redirect_pc   = '0;
        bus.out_ready = 1'b1;

        // Reset values
        repeat (3) tick();
        check("rst_valid", 128'(bus.out_valid),    128'(1'b0));
        check("rst_fault", 128'(misalign_fault),   128'(1'b0));
        check("rst_pc",    128'(bus.out_pc),       128'(0));
        check("rst_instr", 128'(bus.out_instr),    128'(0));

        // E1 issues PC 0, E2 delivers it; unwritten memory reads as NOP
        rst_n = 1'b1;
        tick();
        check("e1_valid", 128'(bus.out_valid), 128'(1'b0));
        tick();
        expect_bundle("e2", 64'h0, NOP2);
        tick();
        expect_bundle("e3", 64'h8, NOP2);

        // Program load then refetch from 0
        load_word(16'h0000, 32'h00148493);
        load_word(16'h0004, 32'h015A04B3);
        load_word(16'h0008, 32'h00148593);
        load_word(16'h000C, 32'h00730433);
        redirect(64'h0);
        check("rd0_r0_valid", 128'(bus.out_valid), 128'(1'b0));
        tick();
        check("rd0_r1_valid", 128'(bus.out_valid), 128'(1'b0));
        tick();
        expect_bundle("prog0", 64'h0,  64'h015A04B3_00148493);
        tick();
        expect_bundle("prog8", 64'h8,  64'h00730433_00148593);
        tick();
        expect_bundle("prog10", 64'h10, NOP2);
        tick();
        expect_bundle("prog18", 64'h18, NOP2);

        // Back-pressure: queue fills to QDEPTH, then drains in order
        bus.out_ready = 1'b0;
        redirect(64'h0);
        repeat (9) tick();
        check("bp_count", 128'(dut.u_queue.count_o), 128'(QDEPTH));
        expect_bundle("bp_head", 64'h0, 64'h015A04B3_00148493);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("drain%0d_valid", k), 128'(bus.out_valid), 128'(1'b1));
            check($sformatf("drain%0d_pc", k),    128'(bus.out_pc),    128'(k * 8));
            tick();
        end

        // Redirect while full with out_ready=1: flush wins over pop
        bus.out_ready = 1'b0;
        repeat (6) tick();
        check("full_count", 128'(dut.u_queue.count_o), 128'(QDEPTH));
        bus.out_ready = 1'b1;
        redirect(64'h154);
        check("rf_r0_valid", 128'(bus.out_valid),         128'(1'b0));
        check("rf_r0_count", 128'(dut.u_queue.count_o),   128'(0));
        tick();
        check("rf_r1_valid", 128'(bus.out_valid), 128'(1'b0));
        tick();
        expect_bundle("rf_154", 64'h154, NOP2);

        // Misaligned redirect: sticky fault, fetch halted
        redirect(64'h156);
        check("mis_fault", 128'(misalign_fault),  128'(1'b1));
        check("mis_valid", 128'(bus.out_valid),   128'(1'b0));
        repeat (3) tick();
        check("mis_hold_fault", 128'(misalign_fault), 128'(1'b1));
        check("mis_hold_valid", 128'(bus.out_valid),  128'(1'b0));
        redirect(64'h100);
        check("clr_fault",    128'(misalign_fault), 128'(1'b0));
        check("clr_r0_valid", 128'(bus.out_valid),  128'(1'b0));
        tick();
        check("clr_r1_valid", 128'(bus.out_valid),  128'(1'b0));
        tick();
        expect_bundle("clr_100", 64'h100, NOP2);

        // Address wrap with simultaneous load + redirect
        load_en     = 1'b1;
        load_addr   = 16'hFFFC;
        load_data   = 32'hCAFEF00D;
        redirect(64'hFFFC);
        load_en     = 1'b0;
        tick();
        tick();
        expect_bundle("wrap_fffc",  64'hFFFC,  64'h00148493_CAFEF00D);
        tick();
        expect_bundle("wrap_10004", 64'h10004, 64'h00148593_015A04B3);

        // Load then redirect onto the freshly written word
        load_word(16'h0020, 32'hDEADBEEF);
        redirect(64'h20);
        tick();
        tick();
        expect_bundle("ld_20", 64'h20, 64'h00000013_DEADBEEF);
        tick();

        // Reset mid-stream wins over a concurrent misaligned redirect
        rst_n       = 1'b0;
        redirect_en = 1'b1;
        redirect_pc = 64'h41;
        tick();
        redirect_en = 1'b0;
        check("mrst_valid", 128'(bus.out_valid),  128'(1'b0));
        check("mrst_fault", 128'(misalign_fault), 128'(1'b0));
        check("mrst_pc",    128'(bus.out_pc),     128'(0));
        check("mrst_instr", 128'(bus.out_instr),  128'(0));
        rst_n = 1'b1;
        tick();
        check("mrst_e1_valid", 128'(bus.out_valid), 128'(1'b0));
        tick();
        expect_bundle("mrst_e2", 64'h0, 64'h015A04B3_00148493);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_instr_fetch_buffer
`default_nettype wire
